// File: rtl/dmem_pkg.sv
// Shared definitions for the unified instruction/data memory:
// RV32I funct3 size codes, init-sweep FSM states and index-width helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dmem_state_t;

    // Number of index bits needed to address 'depth' words.
    function automatic int unsigned dmem_idx_w(input int unsigned depth);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < depth) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I sub-word loads/stores (purely combinational).
// Macro DMEM_MISALIGN_TRAP_EN: when defined, misaligned H/W accesses are
// flagged; otherwise the lane is silently aligned down and misalign stays 0.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic        misalign,
    output logic        st_illegal,
    output logic        ld_illegal,
    output logic [31:0] ld_result
);

    logic [1:0]  eff_lane;
    logic        is_half;
    logic        is_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Effective lane and misalignment detection
    always_comb begin
        is_half = (funct3[1:0] == 2'b01);
        is_word = (funct3[1:0] == 2'b10);
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = (is_half & lane[0]) | (is_word & (lane != 2'b00));
        eff_lane = lane;
`else
        misalign = 1'b0;
        if (is_word)      eff_lane = 2'b00;
        else if (is_half) eff_lane = {lane[1], 1'b0};
        else              eff_lane = lane;
`endif
        st_illegal = !(funct3 inside {F3_B, F3_H, F3_W});
        ld_illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end

    // Store direction: byte enables and replicated write data
    always_comb begin
        byte_en    = '0;
        wdata_lane = '0;
        case (funct3)
            F3_B: begin
                byte_en    = 4'b0001 << eff_lane;
                wdata_lane = {4{wdata[7:0]}};
            end
            F3_H: begin
                byte_en    = eff_lane[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            F3_W: begin
                byte_en    = 4'b1111;
                wdata_lane = wdata;
            end
            default: ;
        endcase
    end

    // Load direction: lane select and sign/zero extension
    always_comb begin
        byte_sel  = rword[{eff_lane, 3'b000} +: 8];
        half_sel  = eff_lane[1] ? rword[31:16] : rword[15:0];
        ld_result = '0;
        case (funct3)
            F3_B:    ld_result = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    ld_result = {{16{half_sel[15]}}, half_sel};
            F3_W:    ld_result = rword;
            F3_BU:   ld_result = {24'd0, byte_sel};
            F3_HU:   ld_result = {16'd0, half_sel};
            default: ld_result = '0;
        endcase
    end

endmodule

// File: rtl/dmem_unified_ls.sv
// Unified instruction-fetch / load-store memory over one word array.
// Registered read responses, error flag on the data port, and a post-reset
// zero-fill sweep gating 'ready'. Optional macro: DMEM_MISALIGN_TRAP_EN.
module dmem_unified_ls
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_valid,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [2:0]        data_funct3,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_valid,
    output logic [31:0]       data_rdata,
    output logic              data_err
);

    localparam int unsigned IDX_W = dmem_idx_w(DEPTH);

    logic [31:0]      mem [DEPTH];
    dmem_state_t      state, state_nxt;
    logic [IDX_W-1:0] clear_ptr, clear_ptr_nxt;

    logic [IDX_W-1:0] inst_idx, data_idx;
    logic             inst_oor, data_oor;
    logic             inst_acc, data_acc;
    logic             data_fault, store_en, clear_en;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_lane, ld_result;
    logic             misalign, st_illegal, ld_illegal;
    logic             unused_inst_lane;

    assign ready            = (state == ST_READY);
    assign inst_idx         = inst_addr[IDX_W+1:2];
    assign data_idx         = data_addr[IDX_W+1:2];
    assign inst_oor         = (inst_addr >> (IDX_W + 2)) != '0;
    assign data_oor         = (data_addr >> (IDX_W + 2)) != '0;
    assign inst_acc         = inst_req & ready;
    assign data_acc         = data_req & ready;
    assign unused_inst_lane = ^inst_addr[1:0];

    dmem_lane_align u_align (
        .funct3     (data_funct3),
        .lane       (data_addr[1:0]),
        .wdata      (data_wdata),
        .rword      (mem[data_idx]),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .misalign   (misalign),
        .st_illegal (st_illegal),
        .ld_illegal (ld_illegal),
        .ld_result  (ld_result)
    );

    assign data_fault = data_oor | misalign | (data_we ? st_illegal : ld_illegal);
    assign store_en   = data_acc & data_we & !data_fault;
    assign clear_en   = (state == ST_CLEAR) & !rst;

    // Next-state logic for the zero-fill sweep
    always_comb begin
        state_nxt     = state;
        clear_ptr_nxt = clear_ptr;
        if (state == ST_CLEAR) begin
            clear_ptr_nxt = clear_ptr + 1'b1;
            if (clear_ptr == IDX_W'(DEPTH - 1)) state_nxt = ST_READY;
        end
    end

    // FSM state and clear pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_CLEAR;
            clear_ptr <= '0;
        end else begin
            state     <= state_nxt;
            clear_ptr <= clear_ptr_nxt;
        end
    end

    // Array writes: sweep zero-fill, otherwise byte-enabled stores
    always_ff @(posedge clk) begin
        if (clear_en) begin
            mem[clear_ptr] <= '0;
        end else if (store_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[data_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
        end
    end

    // Registered responses; fetch reads the pre-store word on a same-edge write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_valid <= 1'b0;
            inst_rdata <= '0;
            data_valid <= 1'b0;
            data_err   <= 1'b0;
            data_rdata <= '0;
        end else begin
            inst_valid <= inst_acc;
            data_valid <= data_acc;
            data_err   <= data_acc & data_fault;
            if (inst_acc) inst_rdata <= inst_oor ? '0 : mem[inst_idx];
            if (data_acc) data_rdata <= (data_we | data_fault) ? '0 : ld_result;
        end
    end

endmodule

// File: tb/tb_dmem_unified_ls.sv
// Self-checking bench for dmem_unified_ls: fixed vector table, randomized
// traffic against a byte-array reference model, and reset corner sequences.
module tb_dmem_unified_ls;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned NBYTES = DEPTH * 4;

    logic              clk;
    logic              rst;
    logic              ready;
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_valid;
    logic [31:0]       inst_rdata;
    logic              data_req;
    logic              data_we;
    logic [2:0]        data_funct3;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_valid;
    logic [31:0]       data_rdata;
    logic              data_err;

    dmem_unified_ls #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_valid  (inst_valid),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_funct3 (data_funct3),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_valid  (data_valid),
        .data_rdata  (data_rdata),
        .data_err    (data_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference storage as plain bytes, little-endian
    logic [7:0] mb [NBYTES];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ireq;
        logic [31:0] iaddr;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vt [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_fetch(input logic [31:0] a);
        int unsigned w;
        if (a >= NBYTES) return 32'd0;
        w = int'(a) & ~3;
        return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
    endfunction

    task automatic model_data(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int unsigned size;
        int unsigned base;
        logic        legal;
        size  = 1 << f3[1:0];
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err   = !legal || (a >= NBYTES);
        rd    = 32'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (legal && (a % size) != 0) err = 1'b1;
`endif
        if (err) return;
        base = int'(a) - int'(a % size);
        if (we) begin
            for (int unsigned i = 0; i < size; i++) mb[base+i] = wd[8*i +: 8];
        end else begin
            for (int unsigned i = 0; i < size; i++) rd[8*i +: 8] = mb[base+i];
            if (!f3[2] && size < 4 && rd[8*size-1]) begin
                for (int unsigned j = 8*size; j < 32; j++) rd[j] = 1'b1;
            end
        end
    endtask

    // Present one cycle of requests; returns #1 after the accepting edge
    task automatic drive(input logic dreq, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic ireq, input logic [31:0] ia);
        data_req    = dreq;
        data_we     = we;
        data_funct3 = f3;
        data_addr   = a;
        data_wdata  = wd;
        inst_req    = ireq;
        inst_addr   = ia;
        @(posedge clk);
        #1;
        data_req = 1'b0;
        inst_req = 1'b0;
    endtask

    task automatic access_chk(input string tag, input logic dreq, input logic we,
                              input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                              input logic ireq, input logic [31:0] ia);
        logic [31:0] exp_inst, exp_rd;
        logic        exp_err;
        exp_inst = model_fetch(ia);
        exp_rd   = 32'd0;
        exp_err  = 1'b0;
        if (dreq) model_data(we, f3, a, wd, exp_rd, exp_err);
        drive(dreq, we, f3, a, wd, ireq, ia);
        chk({tag, ".dvalid"}, data_valid, dreq);
        chk({tag, ".ivalid"}, inst_valid, ireq);
        if (dreq) begin
            chk({tag, ".err"}, data_err, exp_err);
            chk({tag, ".rdata"}, data_rdata, exp_rd);
        end
        if (ireq) chk({tag, ".inst"}, inst_rdata, exp_inst);
    endtask

    // Wait for ready with requests held high; they must be ignored meanwhile
    task automatic wait_ready(input string tag);
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        data_req    = 1'b1;
        data_we     = 1'b1;
        data_funct3 = 3'b010;
        data_addr   = 32'h4;
        data_wdata  = 32'hFFFF_FFFF;
        inst_req    = 1'b1;
        inst_addr   = 32'h4;
        while (!ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (!ready && (data_valid || inst_valid)) seen = 1'b1;
        end
        data_req = 1'b0;
        inst_req = 1'b0;
        chk({tag, ".latency"}, n, DEPTH);
        chk({tag, ".no_valid_in_clear"}, seen, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] ra, ia;

        rst = 1'b1;
        data_req = 1'b0; data_we = 1'b0; data_funct3 = '0; data_addr = '0; data_wdata = '0;
        inst_req = 1'b0; inst_addr = '0;
        for (int i = 0; i < int'(NBYTES); i++) mb[i] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", ready, 1'b0);
        chk("rst.ivalid", inst_valid, 1'b0);
        chk("rst.dvalid", data_valid, 1'b0);
        chk("rst.err", data_err, 1'b0);
        chk("rst.inst", inst_rdata, 32'd0);
        chk("rst.rdata", data_rdata, 32'd0);
        rst = 1'b0;
        wait_ready("init");

        for (int w = 0; w < int'(DEPTH); w++)
            access_chk("zero_lw", 1'b1, 1'b0, 3'b010, 32'(w * 4), 32'd0, 1'b0, 32'd0);

        // Fixed vectors
        vt[0]  = '{1'b1, 3'b010, 32'h08, 32'h80FF7F01, 1'b0, 32'h0, 32'h00000000, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 3'b000, 32'h08, 32'h0,        1'b0, 32'h0, 32'h00000001, 1'b0, 32'h0};
        vt[2]  = '{1'b0, 3'b000, 32'h0B, 32'h0,        1'b0, 32'h0, 32'hFFFFFF80, 1'b0, 32'h0};
        vt[3]  = '{1'b0, 3'b101, 32'h0A, 32'h0,        1'b0, 32'h0, 32'h000080FF, 1'b0, 32'h0};
        vt[4]  = '{1'b0, 3'b001, 32'h0A, 32'h0,        1'b0, 32'h0, 32'hFFFF80FF, 1'b0, 32'h0};
        vt[5]  = '{1'b1, 3'b010, 32'h04, 32'h11223344, 1'b0, 32'h0, 32'h00000000, 1'b0, 32'h0};
        vt[6]  = '{1'b1, 3'b000, 32'h05, 32'h000000AA, 1'b1, 32'h4, 32'h00000000, 1'b0, 32'h11223344};
        vt[7]  = '{1'b0, 3'b010, 32'h04, 32'h0,        1'b1, 32'h8, 32'h1122AA44, 1'b0, 32'h80FF7F01};
        vt[8]  = '{1'b0, 3'b010, 32'h40, 32'h0,        1'b0, 32'h0, 32'h00000000, 1'b1, 32'h0};
        vt[9]  = '{1'b0, 3'b011, 32'h04, 32'h0,        1'b0, 32'h0, 32'h00000000, 1'b1, 32'h0};
        vt[10] = '{1'b0, 3'b010, 32'h04, 32'h0,        1'b0, 32'h0, 32'h1122AA44, 1'b0, 32'h0};
        vt[11] = '{1'b1, 3'b011, 32'h04, 32'h0,        1'b0, 32'h0, 32'h00000000, 1'b1, 32'h0};
        vt[12] = '{1'b0, 3'b010, 32'h04, 32'h0,        1'b1, 32'h44, 32'h1122AA44, 1'b0, 32'h0};
        vt[13] = '{1'b1, 3'b010, 32'h40, 32'h12345678, 1'b0, 32'h0, 32'h00000000, 1'b1, 32'h0};
        vt[14] = '{1'b0, 3'b010, 32'h00, 32'h0,        1'b0, 32'h0, 32'h00000000, 1'b0, 32'h0};
`ifdef DMEM_MISALIGN_TRAP_EN
        vt[15] = '{1'b1, 3'b010, 32'h02, 32'hDEADBEEF, 1'b0, 32'h0, 32'h00000000, 1'b1, 32'h0};
        vt[16] = '{1'b0, 3'b010, 32'h00, 32'h0,        1'b0, 32'h0, 32'h00000000, 1'b0, 32'h0};
`else
        vt[15] = '{1'b1, 3'b010, 32'h02, 32'hDEADBEEF, 1'b0, 32'h0, 32'h00000000, 1'b0, 32'h0};
        vt[16] = '{1'b0, 3'b010, 32'h00, 32'h0,        1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0};
`endif
        for (int i = 0; i < 17; i++) begin
            model_data(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, rd, er);
            drive(1'b1, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, vt[i].ireq, vt[i].iaddr);
            chk($sformatf("vec%0d.dvalid", i), data_valid, 1'b1);
            chk($sformatf("vec%0d.err", i), data_err, vt[i].exp_err);
            chk($sformatf("vec%0d.rdata", i), data_rdata, vt[i].exp_rd);
            if (vt[i].ireq) chk($sformatf("vec%0d.inst", i), inst_rdata, vt[i].exp_inst);
        end

        // Randomized back-to-back traffic on both ports
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, NBYTES + 7));
            ia = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, NBYTES + 7));
            access_chk("rnd", ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)), ra, $urandom,
                       ($urandom_range(0, 3) != 0), ia);
        end

        // In-flight response dropped by an asynchronous reset
        access_chk("pre_rst_sw", 1'b1, 1'b1, 3'b010, 32'h0C, 32'hCAFEF00D, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        chk("async_rst.dvalid", data_valid, 1'b0);
        chk("async_rst.ready", ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_clear.ready", ready, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < int'(NBYTES); i++) mb[i] = 8'h00;
        wait_ready("reclear");
        access_chk("after_reclear", 1'b1, 1'b0, 3'b010, 32'h0C, 32'd0, 1'b1, 32'h08);
        access_chk("idle", 1'b0, 1'b0, 3'b000, 32'h0, 32'd0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_unified_ls.md
Name: dmem_unified_ls

Overview:
- Parametrised successor to the single-cycle RISC-V instruction/data memory.
- Provides one instruction read port and one load/store data port over a shared word array.
- Data accesses are byte-addressed and support RV32I sub-word loads/stores: sign/zero extension and byte lanes.
- Reads are registered with valid strobes; errors are reported on a dedicated flag; the array is zero-filled by a post-reset sweep FSM.
- Sits between the core's fetch/MEM stages and storage; the core stalls on `ready`/`valid`.

Parameters:
- ADDR_W, 32, byte-address width of both ports.
- DEPTH, 1024, number of 32-bit words (power of two, ≥4); IDX_W = log2(DEPTH).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- ready  out  1  high when array is initialised and requests are accepted.
- inst_req  in  1  instruction fetch request.
- inst_addr  in  ADDR_W  fetch byte address.
- inst_valid  out  1  fetch data valid, one cycle after accepted request.
- inst_rdata  out  32  fetched word.
- data_req  in  1  load/store request.
- data_we  in  1  1 = store, 0 = load.
- data_funct3  in  3  RV32I funct3 size/sign code.
- data_addr  in  ADDR_W  data byte address.
- data_wdata  in  32  store data (low bytes used for SB/SH).
- data_valid  out  1  load data / store ack, one cycle after accepted request.
- data_rdata  out  32  extended load result; 0 for stores and errors.
- data_err  out  1  qualifies data_valid; access faulted.

Behaviour:
- Reset (async, rst=1):
  - ready, inst_valid, data_valid, data_err, inst_rdata and data_rdata all go to 0.
  - FSM enters CLEAR with clear_ptr=0.
  - Reset asserted mid-CLEAR or mid-access restarts CLEAR from word 0; any in-flight valid is dropped.
- FSM CLEAR:
  - Writes 0 to word clear_ptr each cycle and increments it.
  - After writing word DEPTH-1, goes to READY on the next edge, so ready rises exactly DEPTH cycles after rst deasserts.
  - In CLEAR, requests are ignored: no valid, no write.
- FSM READY: ready=1 and stays there until the next reset.
- Word index is addr[IDX_W+1:2]; byte lane is addr[1:0].
- Out of range: addr ≥ DEPTH*4, i.e. any addr[ADDR_W-1:IDX_W+2] set.
- Fetch:
  - inst_req & ready → next cycle inst_valid=1, inst_rdata = word[index]; inst_addr[1:0] is ignored.
  - Out-of-range fetch returns 0. There is no fetch error flag.
  - inst_valid is low in any cycle without an accepted request the cycle before.
- Load (data_req & ready & !data_we):
  - Next cycle data_valid=1.
  - funct3 000 LB: sign-extended byte at lane.
  - funct3 001 LH: sign-extended half at addr[1].
  - funct3 010 LW: full word.
  - funct3 100 LBU / 101 LHU: zero-extended byte / half.
- Store (data_req & ready & data_we):
  - funct3 000 SB: writes data_wdata[7:0] to lane addr[1:0]; other bytes unchanged.
  - funct3 001 SH: writes data_wdata[15:0] to lanes addr[1]*2 and addr[1]*2+1.
  - funct3 010 SW: writes all 4 bytes.
  - The write lands on the accepting edge. Next cycle data_valid=1, data_rdata=0.
- Errors: illegal funct3 (load: 011, 110, 111; store: anything other than 000/001/010) or out-of-range address.
  - No write occurs.
  - Next cycle data_valid=1, data_err=1, data_rdata=0.
- Hazards:
  - A fetch in the same cycle as a store to the same word returns the OLD word (read-first).
  - A load issued the cycle after a store sees the NEW data.
  - Simultaneous fetch and data access to any addresses are both served with no stall.
- Throughput: one request per port per cycle, back-to-back.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, is an error.
  - No write occurs; response is data_err=1, data_rdata=0.
- Undefined:
  - Misalignment is never an error. The address is silently aligned: halfword accesses force addr[0]=0; word accesses force addr[1:0]=0.
  - The access then proceeds normally.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - FSM state encoding: ST_CLEAR, ST_READY.
  - Helper for IDX_W computation.
- One sub-module, dmem_lane_align: purely combinational.
  - Store direction: takes funct3, addr[1:0] and wdata; produces 4-bit byte-enable, lane-shifted wdata and misalign/illegal flags.
  - Load direction: takes funct3, addr[1:0] and raw word; produces the extended result.
- The top holds the array, FSM, clear pointer and output registers.

Test Plan:
- Reset, DEPTH=16 → ready rises exactly 16 cycles after rst falls; every LW during READY returns 0x00000000.
- SW 0x80FF7F01 @0x8; then LB @0x8 → 0x00000001; LB @0xB → 0xFFFFFF80; LHU @0xA → 0x000080FF; LH @0xA → 0xFFFF80FF.
- SB 0xAA @0x5 over word 0x11223344 @0x4 → LW @0x4 = 0x1122AA44. In the same cycle as the SB, a fetch @0x4 returns 0x11223344.
- LW @DEPTH*4, and LW with funct3=011 → data_valid=1, data_err=1, rdata=0; the array is unchanged, confirmed by readback.
- SW 0xDEADBEEF @0x2:
  - With macro: err=1 and no write.
  - Without macro: word @0x0 = 0xDEADBEEF.
- Assert rst for one cycle midway through CLEAR after a store → ready stays low for a full DEPTH cycles after release, and the stored word reads back as 0.
